// File: rtl/run_det_pkg.sv
// Shared definitions for the serial run-detector family: FSM encoding,
// polarity-mask constants and found-flag levels.
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    HIT   = 2'b10
  } state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam logic found    = 1'b1;
  localparam logic notfound = 1'b0;

  // Saturating increment of an 8-bit run length, capped at lim.
  function automatic logic [7:0] run_inc(input logic [7:0] cur, input logic [7:0] lim);
    return (cur >= lim) ? lim : cur + 8'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/run_detector.sv
// Moore detector for runs of RUN_LEN identical bits on a sampled serial line,
// with polarity mask, overlap control and a saturating detection count.
module run_detector
  import run_det_pkg::*;
#(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             valid,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             y,
  output logic             pol,
  output logic [7:0]       run_cnt,
  output logic [CNT_W-1:0] det_count
);

  if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
    $error("run_detector: RUN_LEN must be in 2..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("run_detector: CNT_W must be at least 1");
  end

  localparam logic [7:0] RUN_MAX = 8'(RUN_LEN);

  state_t     state, state_n;
  logic       last;
  logic [7:0] cnt, cnt_n;
  logic       hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b0;
      cnt   <= '0;
    end else if (valid) begin
      state <= state_n;
      last  <= x;
      cnt   <= cnt_n;
    end
  end

  // A polarity change or a non-overlapping restart after HIT both begin a new run at 1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hit     = 1'b0;
    if (valid) begin
      if (state == IDLE || x != last) begin
        cnt_n = 8'd1;
      end else if (state == HIT && !overlap) begin
        cnt_n = 8'd1;
      end else begin
        cnt_n = run_inc(cnt, RUN_MAX);
      end
      hit     = (cnt_n == RUN_MAX) && mode[x];
      state_n = hit ? HIT : COUNT;
    end
  end

  always_comb begin
    y       = (state == HIT) ? found : notfound;
    pol     = (state == HIT) ? last : 1'b0;
    run_cnt = cnt;
  end

  sat_counter #(.W(CNT_W)) u_det_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (clr_cnt),
    .q     (det_count)
  );

endmodule

// File: tb/tb_run_detector.sv
// Directed self-checking bench for run_detector (RUN_LEN=3, CNT_W=8 and CNT_W=2).
module tb_run_detector;

  logic       clk = 1'b0;
  logic       reset, x, valid, overlap, clr_cnt;
  logic [1:0] mode;
  logic       y, pol, y2, pol2;
  logic [7:0] run_cnt, run_cnt2;
  logic [7:0] det_count;
  logic [1:0] det_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_detector #(.RUN_LEN(3), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .x(x), .valid(valid), .mode(mode),
    .overlap(overlap), .clr_cnt(clr_cnt), .y(y), .pol(pol),
    .run_cnt(run_cnt), .det_count(det_count)
  );

  run_detector #(.RUN_LEN(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .x(x), .valid(valid), .mode(mode),
    .overlap(overlap), .clr_cnt(clr_cnt), .y(y2), .pol(pol2),
    .run_cnt(run_cnt2), .det_count(det_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid = 1'b0; x = 1'b0; clr_cnt = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    x = 1'b1; valid = 1'b1; mode = 2'b11; overlap = 1'b1;
    tick();
    tick();
    do_reset();
    checks++;
    if ({y, pol, run_cnt, det_count} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got y=%b pol=%b run_cnt=%0d det=%0d exp all 0", y, pol, run_cnt, det_count);
    end
  endtask

  task automatic test_both_nonoverlap();
    logic [5:0] xs = 6'b111000;
    logic [5:0] ey = 6'b100100;
    logic [5:0] ep = 6'b100000;
    logic [7:0] ec [6] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3};
    do_reset();
    mode = 2'b11; overlap = 1'b0; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = xs[i];
      tick();
      checks++;
      if (y !== ey[i] || pol !== ep[i] || run_cnt !== ec[i]) begin
        failures++;
        $display("FAIL both_nonovl[%0d] got y=%b pol=%b run_cnt=%0d exp y=%b pol=%b run_cnt=%0d",
                 i, y, pol, run_cnt, ey[i], ep[i], ec[i]);
      end
    end
    checks++;
    if (det_count !== 8'd2) begin
      failures++;
      $display("FAIL both_nonovl_det got=%0d exp=2", det_count);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] ey_ov = 5'b11100;
    logic [4:0] ey_no = 5'b00100;
    logic [7:0] ec_ov [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    logic [7:0] ec_no [5] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2};
    do_reset();
    mode = 2'b10; overlap = 1'b1; valid = 1'b1; x = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (y !== ey_ov[i] || run_cnt !== ec_ov[i]) begin
        failures++;
        $display("FAIL overlap[%0d] got y=%b run_cnt=%0d exp y=%b run_cnt=%0d", i, y, run_cnt, ey_ov[i], ec_ov[i]);
      end
    end
    checks++;
    if (det_count !== 8'd3) begin
      failures++;
      $display("FAIL overlap_det got=%0d exp=3", det_count);
    end
    do_reset();
    overlap = 1'b0; valid = 1'b1; x = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (y !== ey_no[i] || run_cnt !== ec_no[i]) begin
        failures++;
        $display("FAIL nonoverlap[%0d] got y=%b run_cnt=%0d exp y=%b run_cnt=%0d", i, y, run_cnt, ey_no[i], ec_no[i]);
      end
    end
    checks++;
    if (det_count !== 8'd1) begin
      failures++;
      $display("FAIL nonoverlap_det got=%0d exp=1", det_count);
    end
  endtask

  task automatic test_mode();
    logic [5:0] xs = 6'b000111;
    logic [5:0] ey0 = 6'b100000;
    logic [7:0] ec [6] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3};
    do_reset();
    mode = 2'b01; overlap = 1'b0; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = xs[i];
      tick();
      checks++;
      if (y !== ey0[i] || pol !== 1'b0 || run_cnt !== ec[i]) begin
        failures++;
        $display("FAIL mode_zero[%0d] got y=%b pol=%b run_cnt=%0d exp y=%b pol=0 run_cnt=%0d",
                 i, y, pol, run_cnt, ey0[i], ec[i]);
      end
    end
    checks++;
    if (det_count !== 8'd1) begin
      failures++;
      $display("FAIL mode_zero_det got=%0d exp=1", det_count);
    end
    do_reset();
    mode = 2'b00; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = xs[i];
      tick();
      checks++;
      if (y !== 1'b0 || run_cnt !== ec[i]) begin
        failures++;
        $display("FAIL mode_off[%0d] got y=%b run_cnt=%0d exp y=0 run_cnt=%0d", i, y, run_cnt, ec[i]);
      end
    end
    checks++;
    if (det_count !== 8'd0) begin
      failures++;
      $display("FAIL mode_off_det got=%0d exp=0", det_count);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    mode = 2'b11; overlap = 1'b0; x = 1'b1; valid = 1'b1;
    tick();
    tick();
    valid = 1'b0; x = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (y !== 1'b0 || run_cnt !== 8'd2) begin
        failures++;
        $display("FAIL gap_hold[%0d] got y=%b run_cnt=%0d exp y=0 run_cnt=2", i, y, run_cnt);
      end
    end
    x = 1'b1; valid = 1'b1;
    tick();
    checks++;
    if (y !== 1'b1 || pol !== 1'b1 || run_cnt !== 8'd3) begin
      failures++;
      $display("FAIL gap_hit got y=%b pol=%b run_cnt=%0d exp y=1 pol=1 run_cnt=3", y, pol, run_cnt);
    end
    valid = 1'b0; x = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (y !== 1'b1 || pol !== 1'b1 || det_count !== 8'd1) begin
        failures++;
        $display("FAIL gap_y_hold[%0d] got y=%b pol=%b det=%0d exp y=1 pol=1 det=1", i, y, pol, det_count);
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    mode = 2'b11; overlap = 1'b0; x = 1'b0; valid = 1'b1;
    tick();
    tick();
    checks++;
    if (run_cnt !== 8'd2) begin
      failures++;
      $display("FAIL midrun_pre got run_cnt=%0d exp=2", run_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({y, pol, run_cnt, det_count} !== 18'd0) begin
      failures++;
      $display("FAIL midrun_reset got y=%b pol=%b run_cnt=%0d det=%0d exp all 0", y, pol, run_cnt, det_count);
    end
    tick();
    checks++;
    if (y !== 1'b0 || run_cnt !== 8'd1) begin
      failures++;
      $display("FAIL midrun_after got y=%b run_cnt=%0d exp y=0 run_cnt=1", y, run_cnt);
    end
  endtask

  task automatic test_saturate_clear();
    logic [1:0] ed2 [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    mode = 2'b10; overlap = 1'b1; x = 1'b1; valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (det_count2 !== ed2[i]) begin
        failures++;
        $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, det_count2, ed2[i]);
      end
    end
    checks++;
    if (det_count !== 8'd5) begin
      failures++;
      $display("FAIL sat_cnt8 got=%0d exp=5", det_count);
    end
    clr_cnt = 1'b1;
    tick();
    checks++;
    if (y !== 1'b1 || det_count !== 8'd0 || det_count2 !== 2'd0) begin
      failures++;
      $display("FAIL clr_with_hit got y=%b det=%0d det2=%0d exp y=1 det=0 det2=0", y, det_count, det_count2);
    end
    clr_cnt = 1'b0;
    tick();
    checks++;
    if (det_count !== 8'd1 || det_count2 !== 2'd1) begin
      failures++;
      $display("FAIL count_after_clr got det=%0d det2=%0d exp 1 1", det_count, det_count2);
    end
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; valid = 1'b0; mode = 2'b00; overlap = 1'b0; clr_cnt = 1'b0;
    test_reset();
    test_both_nonoverlap();
    test_overlap();
    test_mode();
    test_gaps();
    test_reset_midrun();
    test_saturate_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised Moore detector for runs of identical bits on a serial input. It asserts `y` once the last `RUN_LEN` accepted samples are all 0 or all 1, with a run-time selectable polarity mask and overlap mode. It also keeps a saturating count of detections. Next-generation replacement for the fixed 3-bit "000 or 111" recogniser in the serial-pattern FSM family; it sits directly on a sampled serial line.

## Interface
Parameters:
- `RUN_LEN`, default 3: run length to detect. Legal range 2..255; any other value is an elaboration error.
- `CNT_W`, default 8: width of the detection counter, ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `x`  in  1  serial data bit.
- `valid`  in  1  sample enable; `x` is accepted only on edges where `valid`=1.
- `mode`  in  2  polarity mask:
  - 2'b01: runs of 0.
  - 2'b10: runs of 1.
  - 2'b11: both.
  - 2'b00: detection disabled; run tracking continues.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `clr_cnt`  in  1  synchronous clear of `det_count`.
- `y`  out  1  found flag, decoded from state (Moore).
- `pol`  out  1  polarity of the detected run; valid while `y`=1, 0 otherwise.
- `run_cnt`  out  8  current run length, saturating at `RUN_LEN`.
- `det_count`  out  CNT_W  number of detections, saturating at all-ones.

## Operation
State machine states are IDLE (no sample seen since reset), COUNT and HIT. Internal registers are `last` (previous accepted bit) and `cnt` (0..RUN_LEN).

On each accepted sample (`valid`=1), compute `cnt_n`:
- `cnt_n` = 1 if state = IDLE or `x` ≠ `last`.
- Else `cnt_n` = 1 if state = HIT and `overlap` = 0.
- Else `cnt_n` = min(`cnt`+1, `RUN_LEN`).

Hit condition: `cnt_n` = `RUN_LEN` and `mode[x]` = 1.

Next state is HIT on a hit, otherwise COUNT. Then `last` ← `x` and `cnt` ← `cnt_n`.

With `valid`=0, all state, `last`, `cnt` and outputs hold.

Outputs:
- `y` = (state == HIT).
- `pol` = `last` when in HIT, else 0.
- `run_cnt` = `cnt`, zero-extended.

`det_count`:
- Increments by 1 on every accepted sample that produces a hit. This includes consecutive hits in overlap mode.
- Saturates at 2^CNT_W−1.
- `clr_cnt`=1 sets it to 0. If a clear coincides with a hit, the clear wins and the result is 0.

Changes to `mode` and `overlap` apply to the next accepted sample. A run already in progress is not discarded.

Reset (`reset`=1 on a clock edge) overrides every other input:
- state = IDLE, `last` = 0, `cnt` = 0.
- `y` = 0, `pol` = 0, `run_cnt` = 0, `det_count` = 0.

Reset mid-run discards the partial run. The first sample after reset always starts a new run with `cnt` = 1.

## Timing
- Latency: the sample completing a run is accepted at edge N; `y` = 1 from edge N to edge N+1 (one cycle after the sample is presented).
- `y` remains high until the next accepted sample, so a stalled stream (`valid`=0) keeps `y` asserted.
- With `overlap`=1 and a continuous run, `y` stays high for every further matching sample, and `det_count` increments on each one.
- With `overlap`=0, a run of length 2·`RUN_LEN` gives exactly 2 hits, `RUN_LEN` samples apart.
- No combinational path from inputs to outputs.

## Structure
- Shared package `run_det_pkg` holds:
  - state encoding constants: IDLE = 2'b00, COUNT = 2'b01, HIT = 2'b10;
  - mode constants `MODE_OFF`, `MODE_ZERO`, `MODE_ONE`, `MODE_BOTH`;
  - the `found`/`notfound` output constants.
- One sub-module, `sat_counter` (parameter `W`; inputs `clk`, `reset`, `inc`, `clr`; output `q`), implements `det_count`. It is reusable by later detectors.
- Next-state logic, state register and output decode are separate processes inside `run_detector`.

## Test plan
- RUN_LEN=3, mode=2'b11, overlap=0, stream 0,0,0,1,1,1 with `valid`=1 → `y` high in the cycles after the 3rd and 6th samples, `pol` = 0 then 1, `det_count` = 2.
- RUN_LEN=3, mode=2'b10, overlap=1, five consecutive 1s → `y` high after samples 3, 4 and 5; `det_count` = 3. Repeat with overlap=0 → one hit after sample 3, none after 4 or 5, `run_cnt` = 2 after sample 5.
- mode=2'b01, stream 1,1,1,0,0,0 → no hit on the ones, hit on the zeros; mode=2'b00 on the same stream → `y` never high, `run_cnt` reaches 3.
- Gaps: stream 1,1 with `valid` low for 4 cycles, then 1 → hit after the 3rd accepted 1; `y` holds through a later `valid`-low gap.
- Reset asserted after two 0s, then 0 → no hit, `run_cnt` = 1. All outputs are 0 on the cycle after reset.
- CNT_W=2, overlap=1, seven 1s → `det_count` saturates at 3. `clr_cnt` asserted together with a hit → `det_count` = 0.
